default_block_adc_tagger: RTL

Receive-side counterpart of the transmit hold path: accepts the raw, non-backpressurable ADC sample stream, each sample carrying its sample index, and produces the tagged AXI-Stream consumed by the host DMA. Each contiguous capture burst is framed as SOB tag, timestamp tag (RWT_TAG_HOLD, payload = sample index of the first sample), samples, EOB tag. Because the timestamp uses the HOLD payload format, a captured stream replayed into the TX hold logic starts at the same sample index. Index discontinuities, caused by dropped samples or by disable, close the burst and start a new one with a fresh timestamp.

---
 rtl/default_block_adc_tagger_if.sv | 23 ++
 rtl/default_block_adc_tagger.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/default_block_adc_tagger_if.sv
// Sample-in / tagged-stream-out bundle for the ADC receive tagger.
// The tagger takes the slave view; the sample source / DMA side takes master.
interface default_block_adc_tagger_if;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] s_data;
   logic [55:0] sample_idx;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_data;
   logic        m_tag_valid;
   logic [6:0]  m_tag_type;

   modport slave (
      input  s_valid, s_data, sample_idx, m_ready,
      output s_ready, m_valid, m_data, m_tag_valid, m_tag_type
   );

   modport master (
      output s_valid, s_data, sample_idx, m_ready,
      input  s_ready, m_valid, m_data, m_tag_valid, m_tag_type
   );
endinterface

// File: rtl/default_block_adc_tagger.sv
// ADC receive tagger: buffers indexed samples and frames each contiguous run
// as SOB, HOLD timestamp, samples, EOB on a registered AXI-Stream output.
module default_block_adc_tagger #(
   parameter int FIFO_AW = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cfg_enable,
   input  logic [31:0]                       cfg_burst_len,
   default_block_adc_tagger_if.slave         bus,
   output logic                              rx_active,
   output logic [31:0]                       overflow_count
);
   localparam logic [6:0] RWT_TAG_SOB  = 7'h01;
   localparam logic [6:0] RWT_TAG_HOLD = 7'h02;
   localparam logic [6:0] RWT_TAG_EOB  = 7'h03;
   localparam int DEPTH = 1 << FIFO_AW;

   typedef struct packed {
      logic [55:0] idx;
      logic [63:0] data;
   } entry_t;

   // State names the beat held in the output register (DATA: sample or empty).
   typedef enum logic [2:0] {IDLE, SOB, TS, DATA, EOB} state_t;

   entry_t             mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   fill;
   logic               empty, full, push, pop, drop;
   entry_t             head;

   state_t             state, state_n;
   logic [31:0]        count, cnt_n, eff_cnt, burst_len;
   logic [55:0]        exp_idx, exp_n, eff_exp;
   logic               hs, free, load, clr, latch_len, eval;
   logic               ld_tv;
   logic [6:0]         ld_tag;
   logic [63:0]        ld_data;

   assign empty = (fill == '0);
   assign full  = (fill == (FIFO_AW+1)'(DEPTH));
   assign head  = mem[rd_ptr];
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push  = bus.s_valid && (!full || pop);
   assign drop  = bus.s_valid && full && !pop;
   assign hs    = bus.m_valid && bus.m_ready;
   assign free  = !bus.m_valid || bus.m_ready;

   // Sample storage; contents need no reset, pointers guard validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{idx: bus.sample_idx, data: bus.s_data};
   end

   // FIFO pointers, occupancy, overflow counter and the always-ready strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fill           <= '0;
         overflow_count <= '0;
         bus.s_ready    <= 1'b0;
      end else begin
         bus.s_ready <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fill <= fill + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
         if (drop && overflow_count != '1) overflow_count <= overflow_count + 32'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state and next output beat; a beat is only loaded when the stage is free.
   always_comb begin
      state_n   = state;
      pop       = 1'b0;
      load      = 1'b0;
      clr       = 1'b0;
      ld_tv     = 1'b0;
      ld_tag    = '0;
      ld_data   = '0;
      latch_len = 1'b0;
      eval      = 1'b0;
      eff_cnt   = count;
      eff_exp   = exp_idx;
      case (state)
         IDLE: if (!empty) begin
            if (!cfg_enable) pop = 1'b1;
            else begin
               load = 1'b1; ld_tv = 1'b1; ld_tag = RWT_TAG_SOB;
               latch_len = 1'b1; state_n = SOB;
            end
         end
         SOB: if (hs) begin
            load = 1'b1; ld_tv = 1'b1; ld_tag = RWT_TAG_HOLD;
            ld_data = {8'h00, head.idx}; state_n = TS;
         end
         // The first sample follows the timestamp without a bubble.
         TS: if (hs) begin
            eval = 1'b1; eff_cnt = '0; eff_exp = head.idx; state_n = DATA;
         end
         DATA: eval = free;
         EOB: if (hs) begin
            clr = 1'b1; state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      cnt_n = eff_cnt;
      exp_n = eff_exp;
      if (eval) begin
         if (burst_len != '0 && eff_cnt == burst_len) begin
            load = 1'b1; ld_tv = 1'b1; ld_tag = RWT_TAG_EOB; state_n = EOB;
         end else if (empty) begin
            clr = 1'b1;
         end else if (!cfg_enable || head.idx != eff_exp) begin
            load = 1'b1; ld_tv = 1'b1; ld_tag = RWT_TAG_EOB; state_n = EOB;
         end else begin
            load = 1'b1; ld_data = head.data; pop = 1'b1;
            cnt_n = eff_cnt + 32'd1;
            exp_n = eff_exp + 56'd1;
         end
      end
   end

   // Burst bookkeeping, output register and rx_active flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count           <= '0;
         exp_idx         <= '0;
         burst_len       <= '0;
         rx_active       <= 1'b0;
         bus.m_valid     <= 1'b0;
         bus.m_data      <= '0;
         bus.m_tag_valid <= 1'b0;
         bus.m_tag_type  <= '0;
      end else begin
         count   <= cnt_n;
         exp_idx <= exp_n;
         if (latch_len) burst_len <= cfg_burst_len;
         if (state == SOB && hs)      rx_active <= 1'b1;
         else if (state == EOB && hs) rx_active <= 1'b0;
         if (load) begin
            bus.m_valid     <= 1'b1;
            bus.m_data      <= ld_data;
            bus.m_tag_valid <= ld_tv;
            bus.m_tag_type  <= ld_tag;
         end else if (clr) begin
            bus.m_valid     <= 1'b0;
            bus.m_data      <= '0;
            bus.m_tag_valid <= 1'b0;
            bus.m_tag_type  <= '0;
         end
      end
   end
endmodule
